// File: rtl/dly_arb.sv
// Round-robin arbiter feeding one registered, index-tagged output stream.
// Optional packet lock (hold grant until end-of-packet) enabled by DLY_ARB_PKT_LOCK_EN.
module dly_arb #(
  parameter  int NUM_IN = 4,
  parameter  int W_DIN  = 16,
  localparam int W_IDX  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
  localparam int W_DOUT = W_IDX + W_DIN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*W_DIN-1:0] din_data,
  input  logic [NUM_IN-1:0]       din_valid,
  output logic [NUM_IN-1:0]       din_ready,
  output logic [W_DOUT-1:0]       dout_data,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    idle
);

  logic [W_DIN-1:0]  din_arr [NUM_IN];
  logic [W_IDX-1:0]  rr_ptr_reg;
  logic [W_DOUT-1:0] dout_data_reg;
  logic              dout_valid_reg;
  logic [W_IDX-1:0]  grant;
  logic              any_valid;
  logic              can_load;
  logic              xfer;
  int                cand;

`ifdef DLY_ARB_PKT_LOCK_EN
  logic              lock_reg;
  logic [W_IDX-1:0]  lock_idx_reg;
`endif

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_lane
      assign din_arr[gi]   = din_data[gi*W_DIN +: W_DIN];
      assign din_ready[gi] = xfer && (grant == W_IDX'(gi));
    end
  endgenerate

  // Scan from farthest to nearest so the nearest valid index after rr_ptr wins.
  always_comb begin
    grant     = rr_ptr_reg;
    any_valid = 1'b0;
    cand      = 0;
    for (int k = NUM_IN; k >= 1; k--) begin
      cand = (int'(rr_ptr_reg) + k) % NUM_IN;
      if (din_valid[cand]) begin
        grant     = W_IDX'(cand);
        any_valid = 1'b1;
      end
    end
`ifdef DLY_ARB_PKT_LOCK_EN
    if (lock_reg) begin
      grant     = lock_idx_reg;
      any_valid = din_valid[lock_idx_reg];
    end
`endif
  end

  assign can_load = !dout_valid_reg || dout_ready;
  assign xfer     = can_load && any_valid && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid_reg <= 1'b0;
      dout_data_reg  <= '0;
      rr_ptr_reg     <= W_IDX'(NUM_IN - 1);
    end else if (xfer) begin
      dout_valid_reg <= 1'b1;
      dout_data_reg  <= {grant, din_arr[grant]};
      rr_ptr_reg     <= grant;
    end else if (dout_ready) begin
      dout_valid_reg <= 1'b0;
    end
  end

`ifdef DLY_ARB_PKT_LOCK_EN
  // Data MSB is the end-of-packet flag; a non-final beat pins the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_reg     <= 1'b0;
      lock_idx_reg <= '0;
    end else if (xfer) begin
      lock_reg     <= !din_arr[grant][W_DIN-1];
      lock_idx_reg <= grant;
    end
  end
`endif

  assign dout_data  = dout_data_reg;
  assign dout_valid = dout_valid_reg;
  assign idle       = !dout_valid_reg && !(|din_valid);

endmodule

// File: tb/tb_dly_arb.sv
// Self-checking bench for dly_arb (NUM_IN=4, W_DIN=16): directed table,
// hand sequences, and randomized traffic against a spec-level model.
module tb_dly_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] din_data;
  logic [3:0]  din_valid;
  logic [3:0]  din_ready;
  logic [17:0] dout_data;
  logic        dout_valid;
  logic        dout_ready;
  logic        idle;
  logic [15:0] d [4];

  assign din_data = {d[3], d[2], d[1], d[0]};

  always #5 clk = ~clk;

  dly_arb #(.NUM_IN(4), .W_DIN(16)) dut (
    .clk(clk), .rst(rst),
    .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .idle(idle)
  );

`ifdef DLY_ARB_PKT_LOCK_EN
  localparam logic [15:0] EOT = 16'h8000;
  localparam bit LOCK_ON = 1'b1;
`else
  localparam logic [15:0] EOT = 16'h0000;
  localparam bit LOCK_ON = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic        m_valid = 1'b0;
  logic [17:0] m_data = '0;
  int          m_rr = 3;
  bit          m_lock = 1'b0;
  int          m_lock_idx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] data_of(input int i);
    return EOT | (16'h1232 + 16'(i));
  endfunction

  function automatic logic [17:0] beat(input int i);
    return {2'(i), data_of(i)};
  endfunction

  function automatic void mgrant(input logic [3:0] v, output int g, output bit any);
    any = 1'b0;
    g = 0;
    if (m_lock) begin
      g = m_lock_idx;
      any = v[g];
    end else begin
      for (int k = 1; k <= 4; k++) begin
        int c = (m_rr + k) % 4;
        if (!any && v[c]) begin
          g = c;
          any = 1'b1;
        end
      end
    end
  endfunction

  // One clock: drive, sample at the falling edge, check vs model, step model.
  task automatic cycle(input logic r, input logic [3:0] v, input logic ordy,
                       output logic [3:0] rdy, output logic ov,
                       output logic [17:0] od, output logic idl);
    int g;
    bit any, xf;
    logic [3:0] er;
    rst = r;
    din_valid = v;
    dout_ready = ordy;
    #4;
    rdy = din_ready;
    ov = dout_valid;
    od = dout_data;
    idl = idle;
    mgrant(v, g, any);
    xf = !r && any && (!m_valid || ordy);
    er = xf ? 4'(1 << g) : 4'b0;
    if (chk_en) begin
      chk("model_ready", 32'(rdy), 32'(er));
      chk("model_valid", 32'(ov), 32'(m_valid));
      if (m_valid) chk("model_data", 32'(od), 32'(m_data));
      chk("model_idle", 32'(idl), 32'(!m_valid && v == 4'b0));
    end
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0;
      m_data = '0;
      m_rr = 3;
      m_lock = 1'b0;
    end else if (xf) begin
      m_valid = 1'b1;
      m_data = {2'(g), d[g]};
      m_rr = g;
      if (LOCK_ON) begin
        m_lock = !d[g][15];
        m_lock_idx = g;
      end
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  typedef struct {
    logic        r;
    logic [3:0]  v;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [17:0] od;
    logic        idl;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [3:0] rdy, v;
    logic ov, idl;
    logic [17:0] od;
    logic [15:0] pkt0 [3];
    logic [15:0] pkt1 [2];
    int exp_lock [5];
    int got [$];
    int n0, n1;

    for (int i = 0; i < 4; i++) d[i] = '0;

    // Reset then idle
    cycle(1, 4'b0, 1, rdy, ov, od, idl);
    chk_en = 1'b1;
    cycle(1, 4'b0, 1, rdy, ov, od, idl);
    chk("rst_ready", 32'(rdy), 32'h0);
    chk("rst_valid", 32'(ov), 32'h0);
    chk("rst_idle", 32'(idl), 32'h1);
    for (int i = 0; i < 2; i++) begin
      cycle(0, 4'b0, 1, rdy, ov, od, idl);
      chk("post_rst_idle", 32'(idl), 32'h1);
      chk("post_rst_valid", 32'(ov), 32'h0);
    end

    // Sparse requests, backpressure, mid-operation reset
    tbl[0]  = '{0, 4'b0100, 1, 4'b0100, 0, 18'h0,    0};
    tbl[1]  = '{0, 4'b1010, 1, 4'b1000, 1, beat(2),  0};
    tbl[2]  = '{0, 4'b0010, 1, 4'b0010, 1, beat(3),  0};
    tbl[3]  = '{0, 4'b0000, 1, 4'b0000, 1, beat(1),  0};
    tbl[4]  = '{0, 4'b0000, 1, 4'b0000, 0, beat(1),  1};
    tbl[5]  = '{0, 4'b1111, 0, 4'b0100, 0, beat(1),  0};
    tbl[6]  = '{0, 4'b1111, 0, 4'b0000, 1, beat(2),  0};
    tbl[7]  = '{0, 4'b1111, 0, 4'b0000, 1, beat(2),  0};
    tbl[8]  = '{0, 4'b1111, 0, 4'b0000, 1, beat(2),  0};
    tbl[9]  = '{0, 4'b1111, 1, 4'b1000, 1, beat(2),  0};
    tbl[10] = '{0, 4'b1111, 1, 4'b0001, 1, beat(3),  0};
    tbl[11] = '{1, 4'b1111, 0, 4'b0000, 1, beat(0),  0};
    tbl[12] = '{0, 4'b1010, 0, 4'b0010, 0, 18'h0,    0};
    tbl[13] = '{0, 4'b0000, 1, 4'b0000, 1, beat(1),  0};
    tbl[14] = '{0, 4'b0000, 1, 4'b0000, 0, beat(1),  1};
    for (int i = 0; i < 4; i++) d[i] = data_of(i);
    for (int t = 0; t < 15; t++) begin
      cycle(tbl[t].r, tbl[t].v, tbl[t].ordy, rdy, ov, od, idl);
      chk($sformatf("tbl%0d_ready", t), 32'(rdy), 32'(tbl[t].rdy));
      chk($sformatf("tbl%0d_valid", t), 32'(ov), 32'(tbl[t].ov));
      chk($sformatf("tbl%0d_data", t), 32'(od), 32'(tbl[t].od));
      chk($sformatf("tbl%0d_idle", t), 32'(idl), 32'(tbl[t].idl));
      $display("[TB] vec %0d rst=%0b v=%b ordy=%0b -> ready=%b ov=%0b od=%h idle=%0b",
               t, tbl[t].r, tbl[t].v, tbl[t].ordy, rdy, ov, od, idl);
    end

    // Full-rate rotation
    for (int i = 0; i < 4; i++) d[i] = 16'hA000 + 16'(i);
    cycle(1, 4'b1111, 1, rdy, ov, od, idl);
    for (int k = 0; k < 9; k++) begin
      cycle(0, 4'b1111, 1, rdy, ov, od, idl);
      if (k == 0) begin
        chk("rot_first_valid", 32'(ov), 32'h0);
      end else begin
        chk($sformatf("rot%0d_valid", k), 32'(ov), 32'h1);
        chk($sformatf("rot%0d_data", k), 32'(od),
            32'({2'((k - 1) % 4), 16'hA000 + 16'((k - 1) % 4)}));
      end
      $display("[TB] rot %0d ov=%0b od=%h", k, ov, od);
    end

    // Packet sequence: din[0] sends 3 beats (eot on last), din[1] sends 2
    pkt0 = '{16'h0C00, 16'h0C01, 16'h8C02};
    pkt1 = '{16'h8B00, 16'h8B01};
    if (LOCK_ON) exp_lock = '{0, 0, 0, 1, 1};
    else         exp_lock = '{0, 1, 0, 1, 0};
    cycle(1, 4'b0, 1, rdy, ov, od, idl);
    n0 = 0;
    n1 = 0;
    for (int c = 0; c < 10; c++) begin
      d[0] = (n0 < 3) ? pkt0[n0] : 16'h0;
      d[1] = (n1 < 2) ? pkt1[n1] : 16'h0;
      v = {2'b00, n1 < 2, n0 < 3};
      cycle(0, v, 1, rdy, ov, od, idl);
      if (ov) got.push_back(int'(od[17:16]));
      if (rdy[0]) n0++;
      if (rdy[1]) n1++;
    end
    chk("pkt_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      chk($sformatf("pkt_idx%0d", i), 32'(got[i]), 32'(exp_lock[i]));
      $display("[TB] pkt beat %0d idx=%0d", i, got[i]);
    end

    // Randomized traffic against the model
    v = 4'b0;
    rdy = 4'b0;
    for (int c = 0; c < 400; c++) begin
      logic r;
      for (int i = 0; i < 4; i++) begin
        if (!v[i] || rdy[i]) begin
          v[i] = 1'($urandom_range(0, 1));
          d[i] = 16'($urandom);
        end
      end
      r = ($urandom_range(0, 49) == 0);
      cycle(r, v, 1'($urandom_range(0, 3) != 0), rdy, ov, od, idl);
      if (r) rdy = 4'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dly_arb.md
Name: dly_arb

Overview:
- Round-robin arbiter that shares one downstream dti datapath (e.g. a multi-stage dreg delay line) between NUM_IN requesters.
- Each accepted beat is tagged with its requester index and registered onto a single dti producer, so the consumer behind the shared datapath can route results back.
- Sits in front of the shared delay/pipeline resource; one output register stage, full throughput.

Parameters:
- NUM_IN, 4, number of requesting dti consumer inputs (>=1)
- W_DIN, 16, data width of each din interface
- W_IDX, derived: NUM_IN>1 ? $clog2(NUM_IN) : 1, width of the index tag
- W_DOUT, derived: W_IDX + W_DIN, dout data width

Ports:
- clk  input  1  clock; all state updates on posedge clk
- rst  input  1  reset, synchronous, active-high
- din[NUM_IN]  dti.consumer  W_DIN  requester streams (data, valid, ready)
- dout  dti.producer  W_DOUT  shared stream; data = {idx[W_IDX-1:0], din_data[W_DIN-1:0]}, idx in MSBs
- idle  output  1  high when dout.valid=0 and no din[i].valid is asserted

Behaviour:
- Reset (rst=1 at a posedge): dout.valid<=0, dout.data<=0, rr_ptr<=NUM_IN-1 (so index 0 has first priority). While rst=1, all din[i].ready=0.
- Output register state: EMPTY (dout.valid=0) or FULL (dout.valid=1). can_load = !dout.valid || dout.ready.
- Arbitration is combinational each cycle. Search order: rr_ptr+1, rr_ptr+2, … wrapping modulo NUM_IN. The grant g is the first index with din[g].valid=1.
- din[i].ready = can_load && (i==g) && any_valid && !rst. At most one ready is high per cycle, and it may depend on dout.ready combinationally.
- Transfer at posedge when din[g].valid && din[g].ready:
  - dout.data <= {g, din[g].data}
  - dout.valid <= 1
  - rr_ptr <= g
- If dout.valid && dout.ready and no input transfer occurs: dout.valid <= 0.
- Simultaneous drain and load: the register reloads in the same cycle with no bubble. Sustained throughput is 1 beat/cycle.
- Latency: din handshake at cycle N -> beat visible on dout from cycle N+1.
- Stall (dout.valid=1, dout.ready=0):
  - dout.data and dout.valid held stable.
  - All din.ready=0.
  - rr_ptr unchanged.
- Fairness: with all inputs continuously valid, grants rotate 0,1,…,NUM_IN-1,0,…. Any valid requester is granted within NUM_IN transfers.
- rr_ptr changes only on a transfer. Idle cycles do not advance it.
- NUM_IN=1: g is always 0, idx field is a constant 0, and the block behaves as a single dreg.
- Mid-operation reset: a beat held in the output register is discarded (dout.valid=0 the cycle after rst). No partial state survives.
- dti rule on inputs: the arbiter never requires din.valid to drop. A requester that is not granted keeps its data and valid stable until granted.

Optional Feature:
- Macro: DLY_ARB_PKT_LOCK_EN.
- Defined:
  - The MSB of each din data word (bit W_DIN-1) is an end-of-packet flag.
  - After a transfer with eot=0 from index g, a lock register is set, holding the grant on g. Other requesters get ready=0 even if g deasserts valid.
  - The lock clears on the transfer whose eot=1; rr_ptr then updates to g.
  - Reset clears the lock.
- Undefined: no lock register; arbitration is strictly per beat and bit W_DIN-1 is ordinary data.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all din.valid=0 -> dout.valid=0, all ready=0, idle=1; after rst deasserts, idle stays 1.
- Full-rate rotation: NUM_IN=4, all din.valid=1 with data 0xA000+i, dout.ready=1 -> dout idx sequence 0,1,2,3,0,1… on consecutive cycles, first beat one cycle after rst release, no bubbles.
- Backpressure: one beat loaded, dout.ready=0 for 5 cycles -> dout.data/valid constant, all din.ready=0, rr_ptr frozen; after ready returns, next grant continues the rotation.
- Sparse requests: only din[2] valid (0x1234), rr_ptr=3 -> grant 2, dout.data={2'd2,16'h1234} next cycle; then din[1] and din[3] valid together -> din[3] wins (search starts at 3), din[1] on the following transfer.
- Mid-operation reset: dout.valid=1 with ready=0, assert rst for 1 cycle -> dout.valid=0 next cycle, rr_ptr=3, first post-reset grant is lowest valid index from 0.
- With DLY_ARB_PKT_LOCK_EN: din[0] sends 3 beats (eot on the 3rd) while din[1] is valid throughout -> dout carries idx 0,0,0 then 1; without the macro -> 0,1,0,1 interleaved.
